move_exec_arbiter: RTL and testbench

- Shares one move_executor instance between two requesters: requester 0 is the UCI front end (position/move commands) and requester 1 is the search/best-move path.
- Serialises requests so the executor sees exactly one valid_in pulse per job, and routes each result back to the requester that issued it.
- Bounds every job with a timeout, so a dead executor cannot hang either requester.
- Sits between uci_handler / search logic and move_executor.

---
 rtl/move_exec_arbiter.sv | 154 +++++++++++++++
 tb/tb_move_exec_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_exec_arbiter.sv
// rtl/move_exec_arbiter.sv - round-robin arbiter sharing one move_executor between two requesters
// Serialises jobs, pulses the executor once per job, routes results back and bounds each job with a timeout.
module move_exec_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7,
  parameter int BOARD_W        = 256,
  parameter int MOVE_W         = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [1:0][BOARD_W-1:0] req_board_in,
  input  logic [1:0][MOVE_W-1:0]  req_move_in,
  input  logic [1:0]              req_valid_in,
  output logic [1:0]              req_ready_out,
  output logic [BOARD_W-1:0]      resp_board_out,
  output logic                    resp_err_out,
  output logic [1:0]              resp_valid_out,
  input  logic [1:0]              resp_ready_in,
  output logic [BOARD_W-1:0]      exec_board_out,
  output logic [MOVE_W-1:0]       exec_move_out,
  output logic                    exec_valid_out,
  input  logic [BOARD_W-1:0]      exec_board_in,
  input  logic                    exec_valid_in,
  output logic                    busy_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t               state;
  state_t               state_nxt;
  logic                 last_grant;
  logic                 grant;
  logic                 arb_pick;
  logic [BOARD_W-1:0]   job_board;
  logic [MOVE_W-1:0]    job_move;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [BOARD_W-1:0]   resp_board;
  logic                 resp_err;
  logic [1:0]           resp_valid;
  logic                 accept;
  logic                 exec_done;
  logic                 timed_out;
  logic                 resp_hs;

  assign cnt_inc = cnt + CNT_ONE;

  // On a tie the requester that did not win last time is picked.
  always_comb begin
    arb_pick = 1'b0;
    case (req_valid_in)
      2'b10:   arb_pick = 1'b1;
      2'b11:   arb_pick = ~last_grant;
      default: arb_pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    req_ready_out  = 2'b00;
    exec_valid_out = 1'b0;
    accept         = 1'b0;
    exec_done      = 1'b0;
    timed_out      = 1'b0;
    resp_hs        = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_in[arb_pick]) begin
          req_ready_out[arb_pick] = 1'b1;
          accept                  = 1'b1;
          state_nxt               = ISSUE;
        end
      end
      ISSUE: begin
        exec_valid_out = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        // A result landing on the final counted cycle still wins over the timeout.
        if (exec_valid_in) begin
          exec_done = 1'b1;
          state_nxt = RESPOND;
        end else if (cnt_inc == TIMEOUT_C) begin
          timed_out = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        if (resp_ready_in[grant]) begin
          resp_hs   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= 1'b1;
      grant      <= 1'b0;
      job_board  <= '0;
      job_move   <= '0;
      cnt        <= '0;
      resp_board <= '0;
      resp_err   <= 1'b0;
      resp_valid <= 2'b00;
    end else begin
      if (accept) begin
        grant     <= arb_pick;
        job_board <= req_board_in[arb_pick];
        job_move  <= req_move_in[arb_pick];
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt_inc;
      end
      if (exec_done) begin
        resp_board <= exec_board_in;
        resp_err   <= 1'b0;
        resp_valid <= {grant, ~grant};
      end else if (timed_out) begin
        resp_board <= job_board;
        resp_err   <= 1'b1;
        resp_valid <= {grant, ~grant};
      end
      if (resp_hs) begin
        resp_valid <= 2'b00;
        resp_err   <= 1'b0;
        last_grant <= grant;
      end
    end
  end

  assign resp_board_out = resp_board;
  assign resp_err_out   = resp_err;
  assign resp_valid_out = resp_valid;
  assign exec_board_out = job_board;
  assign exec_move_out  = job_move;
  assign busy_out       = (state != IDLE);

endmodule

// File: tb/tb_move_exec_arbiter.sv
// tb/tb_move_exec_arbiter.sv - bench for move_exec_arbiter with a stand-in executor
// A job-level model predicts every output each cycle from accept/answer cycle arithmetic.
module tb_move_exec_arbiter;
  localparam int BW = 256;
  localparam int MW = 16;
  localparam int TO = 64;
  localparam logic [BW-1:0] START = 256'hA89CB98A_77777777_00000000_00000000_00000000_00000000_11111111_32456423;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [1:0][BW-1:0] req_board_in = '0;
  logic [1:0][MW-1:0] req_move_in = '0;
  logic [1:0]        req_valid_in = 2'b00;
  logic [1:0]        req_ready_out;
  logic [BW-1:0]     resp_board_out;
  logic              resp_err_out;
  logic [1:0]        resp_valid_out;
  logic [1:0]        resp_ready_in = 2'b00;
  logic [BW-1:0]     exec_board_out;
  logic [MW-1:0]     exec_move_out;
  logic              exec_valid_out;
  logic [BW-1:0]     exec_board_in = '0;
  logic              exec_valid_in = 1'b0;
  logic              busy_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  move_exec_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(7), .BOARD_W(BW), .MOVE_W(MW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_board_in(req_board_in), .req_move_in(req_move_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .resp_board_out(resp_board_out), .resp_err_out(resp_err_out),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .exec_board_out(exec_board_out), .exec_move_out(exec_move_out),
    .exec_valid_out(exec_valid_out), .exec_board_in(exec_board_in),
    .exec_valid_in(exec_valid_in), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [BW-1:0] xform(logic [BW-1:0] b, logic [MW-1:0] m);
    return b ^ {16{m}};
  endfunction

  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[BW-33:0], $urandom};
    return r;
  endfunction

  // Stand-in executor: mode 0 never answers, 1 answers after ex_delay, 2 random delay/timeouts/spurious.
  int            ex_mode = 0;
  int            ex_delay = 1;
  int            ex_r;
  int            spur_at = -1;
  logic          pend = 1'b0;
  int            pend_cyc = 0;
  logic [BW-1:0] pend_board = '0;

  always @(posedge clk_in) begin
    #1;
    exec_valid_in = 1'b0;
    if (pend && cyc == pend_cyc) begin
      exec_valid_in = 1'b1;
      exec_board_in = pend_board;
      pend          = 1'b0;
    end else if (cyc == spur_at || (ex_mode == 2 && $urandom_range(0, 31) == 0)) begin
      exec_valid_in = 1'b1;
      exec_board_in = rand_board();
    end
    if (exec_valid_out && !rst_in) begin
      ex_r = (ex_mode == 1) ? ex_delay : (ex_mode == 2) ? int'($urandom_range(0, 9)) : 0;
      if (ex_r != 0) begin
        pend       = 1'b1;
        pend_cyc   = cyc + ex_r;
        pend_board = xform(exec_board_out, exec_move_out);
      end
    end
  end

  // Job-level reference model, evaluated at the falling edge once inputs are stable.
  logic          m_busy = 1'b0;
  logic          m_last = 1'b1;
  logic          m_grant = 1'b0;
  int            m_acc = 0;
  logic [BW-1:0] m_board = '0;
  logic [MW-1:0] m_move = '0;
  logic          m_has_resp = 1'b0;
  int            m_resp_cyc = 0;
  logic [BW-1:0] m_rboard = '0;
  logic          m_rerr = 1'b0;
  logic [1:0]    exp_ready;
  logic [1:0]    exp_rv;
  int            accepts = 0;
  int            exec_pulses = 0;
  int            last_exec_cyc = 0;

  always @(negedge clk_in) begin
    if (exec_valid_out) begin
      exec_pulses++;
      last_exec_cyc = cyc;
    end
    if (rst_in) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      m_has_resp = 1'b0;
      chk("rst_busy", busy_out, 0);
      chk("rst_exec_valid", exec_valid_out, 0);
      chk("rst_resp_valid", resp_valid_out, 0);
      chk("rst_resp_err", resp_err_out, 0);
    end else if (!m_busy) begin
      exp_ready = 2'b00;
      if (req_valid_in == 2'b01) exp_ready = 2'b01;
      else if (req_valid_in == 2'b10) exp_ready = 2'b10;
      else if (req_valid_in == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
      chk("idle_req_ready", req_ready_out, exp_ready);
      chk("idle_busy", busy_out, 0);
      chk("idle_exec_valid", exec_valid_out, 0);
      chk("idle_resp_valid", resp_valid_out, 0);
      if (exp_ready != 2'b00) begin
        m_busy     = 1'b1;
        m_grant    = exp_ready[1];
        m_acc      = cyc;
        m_board    = req_board_in[exp_ready[1]];
        m_move     = req_move_in[exp_ready[1]];
        m_has_resp = 1'b0;
        accepts++;
      end
    end else begin
      chk("job_req_ready", req_ready_out, 0);
      chk("job_busy", busy_out, 1);
      chk("job_exec_valid", exec_valid_out, (cyc == m_acc + 1));
      if (!m_has_resp) begin
        chk("job_exec_board", exec_board_out, m_board);
        chk("job_exec_move", exec_move_out, m_move);
      end
      exp_rv = (m_has_resp && cyc >= m_resp_cyc) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;
      chk("job_resp_valid", resp_valid_out, exp_rv);
      if (exp_rv != 2'b00) begin
        chk("job_resp_board", resp_board_out, m_rboard);
        chk("job_resp_err", resp_err_out, m_rerr);
        if (resp_ready_in[m_grant]) begin
          m_busy = 1'b0;
          m_last = m_grant;
        end
      end else if (!m_has_resp && cyc >= m_acc + 2) begin
        if (exec_valid_in) begin
          m_has_resp = 1'b1;
          m_resp_cyc = cyc + 1;
          m_rboard   = exec_board_in;
          m_rerr     = 1'b0;
        end else if (cyc == m_acc + 1 + TO) begin
          m_has_resp = 1'b1;
          m_resp_cyc = cyc + 1;
          m_rboard   = m_board;
          m_rerr     = 1'b1;
        end
      end
    end
  end

  task automatic wait_accept(output int g, output int at);
    logic found;
    found = 1'b0;
    g = -1;
    at = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_in);
      if (|(req_valid_in & req_ready_out)) begin
        found = 1'b1;
        g = int'(req_ready_out[1]);
        at = cyc;
      end
    end
    if (!found) chk("accept_timeout", 0, 1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_resp(output int rc);
    logic found;
    found = 1'b0;
    rc = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_in);
      if (resp_valid_out != 2'b00) begin
        found = 1'b1;
        rc = cyc;
      end
    end
    if (!found) chk("resp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk_in);
      if (!busy_out) found = 1'b1;
    end
    if (!found) chk("idle_timeout", 0, 1);
    @(posedge clk_in);
    #1;
  endtask

  int g;
  int at;
  int rc;
  int p0;
  int acc_at[4];
  int grants[4];
  logic [BW-1:0] rb;

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_busy", busy_out, 0);
    chk("reset_exec_board", exec_board_out, 0);
    chk("reset_resp_valid", resp_valid_out, 0);
    rst_in = 1'b0;

    // Single requester 0, e2e4 on the start board, executor answers 3 cycles after the pulse.
    ex_mode = 1; ex_delay = 3;
    resp_ready_in = 2'b01;
    req_board_in[0] = START;
    req_move_in[0] = 16'h031C;
    req_valid_in = 2'b01;
    p0 = exec_pulses;
    wait_accept(g, at);
    req_valid_in = 2'b00;
    chk("t1_grant", g, 0);
    wait_resp(rc);
    chk("t1_resp_valid", resp_valid_out, 2'b01);
    chk("t1_resp_err", resp_err_out, 0);
    chk("t1_resp_board", resp_board_out, xform(START, 16'h031C));
    chk("t1_latency", rc - last_exec_cyc, 4);
    chk("t1_issue_after_accept", last_exec_cyc - at, 1);
    @(negedge clk_in);
    chk("t1_busy_falls", busy_out, 0);
    chk("t1_one_pulse", exec_pulses - p0, 1);

    // Both requesters valid from reset, back-to-back jobs.
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    ex_delay = 1;
    resp_ready_in = 2'b11;
    req_board_in[0] = rand_board(); req_move_in[0] = 16'h1111;
    req_board_in[1] = rand_board(); req_move_in[1] = 16'h2222;
    req_valid_in = 2'b11;
    p0 = exec_pulses;
    for (int k = 0; k < 4; k++) begin
      wait_accept(grants[k], acc_at[k]);
    end
    req_valid_in = 2'b00;
    wait_idle();
    for (int k = 0; k < 4; k++) chk("t2_grant_order", grants[k], k % 2);
    for (int k = 1; k < 4; k++) chk("t2_accept_spacing", acc_at[k] - acc_at[k-1], 4);
    chk("t2_pulses", exec_pulses - p0, 4);

    // Executor never answers: timeout response with the request board.
    ex_mode = 0;
    req_board_in[1] = rand_board(); req_move_in[1] = 16'h0ABC;
    rb = req_board_in[1];
    req_valid_in = 2'b10;
    wait_accept(g, at);
    req_valid_in = 2'b00;
    wait_resp(rc);
    chk("t3_timeout_cycle", rc - last_exec_cyc, 65);
    chk("t3_resp_valid", resp_valid_out, 2'b10);
    chk("t3_resp_err", resp_err_out, 1);
    chk("t3_resp_board", resp_board_out, rb);
    wait_idle();
    ex_mode = 1; ex_delay = 2;
    req_board_in[0] = rand_board(); req_move_in[0] = 16'h0F0F;
    rb = xform(req_board_in[0], 16'h0F0F);
    req_valid_in = 2'b01;
    wait_accept(g, at);
    req_valid_in = 2'b00;
    wait_resp(rc);
    chk("t3_next_err", resp_err_out, 0);
    chk("t3_next_board", resp_board_out, rb);
    wait_idle();

    // Response back-pressure while requester 1 waits; spurious result inside RESPOND.
    resp_ready_in = 2'b00;
    req_board_in[0] = rand_board(); req_move_in[0] = 16'h0123;
    req_valid_in = 2'b01;
    wait_accept(g, at);
    chk("t4_first_grant", g, 0);
    req_valid_in = 2'b10;
    wait_resp(rc);
    rb = resp_board_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      resp_ready_in = i[0] ? 2'b10 : 2'b00;
      if (i == 2) spur_at = cyc + 1;
      @(negedge clk_in);
      chk("t4_board_stable", resp_board_out, rb);
      chk("t4_ready_low", req_ready_out, 0);
      chk("t4_resp_held", resp_valid_out, 2'b01);
    end
    @(posedge clk_in); #1;
    resp_ready_in = 2'b01;
    wait_accept(g, at);
    chk("t4_second_grant", g, 1);
    req_valid_in = 2'b00;
    resp_ready_in = 2'b11;
    wait_idle();

    // Spurious result while idle.
    spur_at = cyc + 1;
    repeat (4) @(negedge clk_in);
    chk("t5_idle_busy", busy_out, 0);
    chk("t5_idle_resp", resp_valid_out, 0);

    // Asynchronous reset in the middle of WAIT, then a late executor answer.
    @(posedge clk_in); #1;
    ex_delay = 20;
    req_board_in[0] = rand_board(); req_move_in[0] = 16'h0777;
    req_valid_in = 2'b01;
    wait_accept(g, at);
    req_valid_in = 2'b00;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t6_async_busy", busy_out, 0);
    chk("t6_async_exec_board", exec_board_out, 0);
    chk("t6_async_exec_move", exec_move_out, 0);
    chk("t6_async_resp_valid", resp_valid_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    chk("t6_late_busy", busy_out, 0);
    chk("t6_late_resp", resp_valid_out, 0);
    @(posedge clk_in); #1;
    ex_delay = 2;
    req_valid_in = 2'b11;
    @(negedge clk_in);
    chk("t6_tie_after_reset", req_ready_out, 2'b01);
    wait_accept(g, at);
    req_valid_in = 2'b00;
    wait_idle();

    // Randomised traffic against the model.
    ex_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk_in); #1;
      req_valid_in = 2'($urandom);
      resp_ready_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_board_in[0] = rand_board(); req_move_in[0] = 16'($urandom);
        req_board_in[1] = rand_board(); req_move_in[1] = 16'($urandom);
      end
    end
    ex_mode = 0;
    req_valid_in = 2'b00;
    resp_ready_in = 2'b11;
    wait_idle();
    repeat (3) @(negedge clk_in);
    chk("pulse_per_accept", exec_pulses, accepts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
